// File: rtl/seg_scan_driver.sv
`default_nettype none

// ============================================================================
// project_pkg
//   Display code set shared with seg_controller.
// Revision: 1.0
// ============================================================================
package project_pkg;
    typedef enum logic [4:0] {
        CODE_0   = 5'd0,
        CODE_1   = 5'd1,
        CODE_2   = 5'd2,
        CODE_3   = 5'd3,
        CODE_4   = 5'd4,
        CODE_5   = 5'd5,
        CODE_6   = 5'd6,
        CODE_7   = 5'd7,
        CODE_8   = 5'd8,
        CODE_9   = 5'd9,
        CODE_A   = 5'd10,
        CODE_B   = 5'd11,
        CODE_C   = 5'd12,
        CODE_D   = 5'd13,
        CODE_E   = 5'd14,
        CODE_H   = 5'd15,
        CODE_J   = 5'd16,
        CODE_P   = 5'd17,
        CODE_R   = 5'd18,
        CODE_T   = 5'd19,
        CODE_BLK = 5'd31
    } code_t;
endpackage

// ============================================================================
// seg_scan_driver
//   Time-multiplexed 8-digit 7-segment scan driver with anti-ghost guard,
//   tear-free frame latching and frame-counted blinking.
// Revision: 1.0
// ============================================================================
module seg_scan_driver #(
    parameter int DIGIT_TICKS  = 100_000,
    parameter int GUARD_TICKS  = 2_000,
    parameter int BLINK_FRAMES = 64
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      en,
    input  project_pkg::code_t [7:0]  seg_display_data,
    input  logic [7:0]                blink_mask,
    output logic [7:0]                seg_an,
    output logic [7:0]                seg_seg,
    output logic                      frame_start
);
    import project_pkg::*;

    localparam int TICK_W  = (DIGIT_TICKS  > 1) ? $clog2(DIGIT_TICKS)  : 1;
    localparam int FRAME_W = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;

    localparam logic [TICK_W-1:0]  TICK_LAST  = TICK_W'(DIGIT_TICKS - 1);
    localparam logic [TICK_W-1:0]  GUARD_END  = TICK_W'(GUARD_TICKS);
    localparam logic [FRAME_W-1:0] FRAME_LAST = FRAME_W'(BLINK_FRAMES - 1);

    logic [TICK_W-1:0]  tick;
    logic [2:0]         scan_idx;
    logic               first_pend;
    code_t [7:0]        shadow_data;
    logic [7:0]         shadow_mask;
    logic [FRAME_W-1:0] frame_cnt;
    logic               blink_phase;

    logic               tick_wrap;
    logic               frame_latch;
    logic               digit_dark;
    logic [7:0]         an_next;
    logic [7:0]         seg_next;

    // Segment pattern for one code; dp stays 0, unknown codes are blank.
    function automatic logic [7:0] decode(input code_t c);
        logic [7:0] s;
        case (c)
            CODE_0:  s = 8'h3F;
            CODE_1:  s = 8'h06;
            CODE_2:  s = 8'h5B;
            CODE_3:  s = 8'h4F;
            CODE_4:  s = 8'h66;
            CODE_5:  s = 8'h6D;
            CODE_6:  s = 8'h7D;
            CODE_7:  s = 8'h07;
            CODE_8:  s = 8'h7F;
            CODE_9:  s = 8'h6F;
            CODE_A:  s = 8'h77;
            CODE_B:  s = 8'h7C;
            CODE_C:  s = 8'h39;
            CODE_D:  s = 8'h5E;
            CODE_E:  s = 8'h79;
            CODE_H:  s = 8'h76;
            CODE_J:  s = 8'h1E;
            CODE_P:  s = 8'h73;
            CODE_R:  s = 8'h50;
            CODE_T:  s = 8'h78;
            default: s = 8'h00;
        endcase
        return s;
    endfunction

    // Slot wrap and frame-latch decision (first cycle out of reset, or end of slot 7).
    always_comb begin
        tick_wrap   = (tick == TICK_LAST);
        frame_latch = !rst && (first_pend || (tick_wrap && (scan_idx == 3'd7)));
    end

    assign frame_start = frame_latch;

    // Slot counter: tick within the slot, scan_idx advances on each slot wrap.
    always_ff @(posedge clk) begin
        if (rst) begin
            tick     <= '0;
            scan_idx <= 3'd0;
        end else if (tick_wrap) begin
            tick     <= '0;
            scan_idx <= scan_idx + 3'd1;
        end else begin
            tick     <= tick + 1'b1;
        end
    end

    // Shadow frame: captured only at frame boundaries so a frame never tears.
    always_ff @(posedge clk) begin
        if (rst) begin
            first_pend <= 1'b1;
            for (int i = 0; i < 8; i++) begin
                shadow_data[i] <= CODE_BLK;
            end
            shadow_mask <= 8'hFF;
        end else begin
            first_pend <= 1'b0;
            if (frame_latch) begin
                shadow_data <= seg_display_data;
                shadow_mask <= blink_mask;
            end
        end
    end

    // Blink timing: count latched frames, flip the phase every BLINK_FRAMES.
    always_ff @(posedge clk) begin
        if (rst) begin
            frame_cnt   <= '0;
            blink_phase <= 1'b0;
        end else if (frame_latch) begin
            if (frame_cnt == FRAME_LAST) begin
                frame_cnt   <= '0;
                blink_phase <= ~blink_phase;
            end else begin
                frame_cnt   <= frame_cnt + 1'b1;
            end
        end
    end

    // Next anode/segment pair for the current slot; dark digits drive nothing.
    always_comb begin
        an_next    = 8'h00;
        seg_next   = 8'h00;
        digit_dark = (tick < GUARD_END) || !en ||
                     (!shadow_mask[scan_idx] && blink_phase);
        if (!digit_dark) begin
            an_next  = 8'b1 << scan_idx;
            seg_next = decode(shadow_data[scan_idx]);
        end
    end

    // Output register: anode and segments update on the same edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            seg_an  <= 8'h00;
            seg_seg <= 8'h00;
        end else begin
            seg_an  <= an_next;
            seg_seg <= seg_next;
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_seg_scan_driver.sv
`default_nettype none

// ============================================================================
// tb_seg_scan_driver
//   Self-checking bench: directed phases plus random frame traffic compared
//   against a cycle-count reference model of the scan driver.
// Revision: 1.0
// ============================================================================
module tb_seg_scan_driver;
    import project_pkg::*;

    localparam int DT = 4;
    localparam int GT = 1;
    localparam int BF = 2;

    logic        clk = 1'b0;
    logic        rst;
    logic        en;
    code_t [7:0] data;
    logic [7:0]  mask;
    logic [7:0]  seg_an;
    logic [7:0]  seg_seg;
    logic        frame_start;

    int checks = 0;
    int errors = 0;

    // Reference model state: cycles since reset release, latched frame, latch count.
    int         t;
    int         nlatch;
    int         m_data [8];
    logic [7:0] m_mask;
    logic [7:0] seg_tbl [32];

    seg_scan_driver #(
        .DIGIT_TICKS  (DT),
        .GUARD_TICKS  (GT),
        .BLINK_FRAMES (BF)
    ) dut (
        .clk              (clk),
        .rst              (rst),
        .en               (en),
        .seg_display_data (data),
        .blink_mask       (mask),
        .seg_an           (seg_an),
        .seg_seg          (seg_seg),
        .frame_start      (frame_start)
    );

    always #5 clk = ~clk;

    task automatic set_digit(input int i, input int v);
        data[i] = code_t'(5'(v));
    endtask

    task automatic model_reset();
        t      = 0;
        nlatch = 0;
        for (int i = 0; i < 8; i++) m_data[i] = 31;
        m_mask = 8'hFF;
    endtask

    // One clock cycle: predict, check frame_start mid-cycle, advance model, check outputs.
    task automatic cyc();
        logic [7:0] e_an;
        logic [7:0] e_seg;
        logic       e_fs;
        int         tk;
        int         sl;
        bit         phase;
        tk    = t % DT;
        sl    = (t / DT) % 8;
        phase = ((nlatch / BF) % 2) == 1;
        e_fs  = !rst && ((t == 0) || ((t % (8 * DT)) == (8 * DT - 1)));
        e_an  = 8'h00;
        e_seg = 8'h00;
        if (!rst && !(tk < GT) && en && !(!m_mask[sl] && phase)) begin
            e_an  = 8'(1 << sl);
            e_seg = seg_tbl[m_data[sl]];
        end
        @(negedge clk);
        checks++;
        assert (frame_start === e_fs) else begin
            errors++;
            $error("FAIL frame_start t=%0d got %b exp %b", t, frame_start, e_fs);
        end
        @(posedge clk);
        if (rst) begin
            model_reset();
        end else begin
            if (e_fs) begin
                for (int i = 0; i < 8; i++) m_data[i] = int'(data[i]);
                m_mask = mask;
                nlatch++;
            end
            t++;
        end
        #1;
        checks++;
        assert (seg_an === e_an) else begin
            errors++;
            $error("FAIL seg_an t=%0d got %h exp %h", t, seg_an, e_an);
        end
        checks++;
        assert (seg_seg === e_seg) else begin
            errors++;
            $error("FAIL seg_seg t=%0d got %h exp %h", t, seg_seg, e_seg);
        end
    endtask

    initial begin
        for (int i = 0; i < 32; i++) seg_tbl[i] = 8'h00;
        seg_tbl[0]  = 8'h3F; seg_tbl[1]  = 8'h06; seg_tbl[2]  = 8'h5B;
        seg_tbl[3]  = 8'h4F; seg_tbl[4]  = 8'h66; seg_tbl[5]  = 8'h6D;
        seg_tbl[6]  = 8'h7D; seg_tbl[7]  = 8'h07; seg_tbl[8]  = 8'h7F;
        seg_tbl[9]  = 8'h6F; seg_tbl[10] = 8'h77; seg_tbl[11] = 8'h7C;
        seg_tbl[12] = 8'h39; seg_tbl[13] = 8'h5E; seg_tbl[14] = 8'h79;
        seg_tbl[15] = 8'h76; seg_tbl[16] = 8'h1E; seg_tbl[17] = 8'h73;
        seg_tbl[18] = 8'h50; seg_tbl[19] = 8'h78;

        // Reset and first latch: {H,E,1,1,0,BLK,BLK,BLK}, steady mask.
        rst  = 1'b1;
        en   = 1'b1;
        mask = 8'hFF;
        set_digit(7, 15); set_digit(6, 14); set_digit(5, 1); set_digit(4, 1);
        set_digit(3, 0);  set_digit(2, 31); set_digit(1, 31); set_digit(0, 31);
        @(posedge clk);
        #1;
        model_reset();
        repeat (3) cyc();
        rst = 1'b0;
        repeat (8 * DT) cyc();

        // Tear-free update: change digit 7 to E during slot 3.
        repeat (3 * DT + 1) cyc();
        set_digit(7, 14);
        repeat (8 * DT - (3 * DT + 1) + 8 * DT) cyc();

        // Blink: digit 7 masked.
        mask = 8'h7F;
        repeat (6 * 8 * DT) cyc();

        // Enable drop for 5 cycles.
        repeat (10) cyc();
        en = 1'b0;
        repeat (5) cyc();
        en = 1'b1;
        repeat (20) cyc();

        // Random traffic, including out-of-enum codes, mask and enable churn.
        for (int n = 0; n < 16 * 8 * DT; n++) begin
            if ($urandom_range(0, 7) == 0)  set_digit($urandom_range(0, 7), $urandom_range(0, 31));
            if ($urandom_range(0, 15) == 0) mask = 8'($urandom);
            if ($urandom_range(0, 19) == 0) en = ~en;
            cyc();
        end
        en = 1'b1;

        // Out-of-enum code in a steadily lit digit.
        mask = 8'hFF;
        set_digit(2, 25);
        repeat (2 * 8 * DT) cyc();

        // Reset mid-frame during slot 5, then restart.
        for (int n = 0; n < 8 * DT && ((t / DT) % 8) != 5; n++) cyc();
        rst = 1'b1;
        repeat (2) cyc();
        rst = 1'b0;
        repeat (2 * 8 * DT) cyc();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/seg_scan_driver.md
# seg_scan_driver

Time-multiplexed scan driver for the board's 8-digit 7-segment display. It takes the frame produced by `seg_controller` (`seg_display_data`, `blink_mask`) and drives the physical anode and segment lines. Each digit is scanned in turn with an anti-ghosting guard interval. A new frame is latched only at frame boundaries, so the display never tears. Masked digits blink at a frame-counted rate. It sits between `seg_controller` and the top-level pins.

## Interface
- `DIGIT_TICKS`, default 100_000: clock cycles per digit slot (1 ms at 100 MHz); must be at least 2.
- `GUARD_TICKS`, default 2_000: cycles at the start of each slot with all anodes off; must be less than `DIGIT_TICKS`.
- `BLINK_FRAMES`, default 64: frames per blink half-period; must be at least 1.
- `clk` input, 1 bit: system clock. One clock domain; reset is synchronous and active-high.
- `rst` input, 1 bit: synchronous active-high reset.
- `en` input, 1 bit: display enable; 0 forces all anodes off, while scanning and blink timing keep running.
- `seg_display_data` input, `code_t [7:0]`: index 7 is the leftmost digit and index 0 the rightmost.
- `blink_mask` input, 8 bits: bit i = 1 shows digit i steadily; bit i = 0 makes digit i blink.
- `seg_an` output, 8 bits: active-high one-hot anode select; bit i drives digit i.
- `seg_seg` output, 8 bits: active-high segments, ordered {dp,g,f,e,d,c,b,a}.
- `frame_start` output, 1 bit: one-cycle pulse on the cycle the shadow frame is latched.

## Operation
- **Slot counter**
  - `tick` counts 0..`DIGIT_TICKS`-1 and wraps to 0.
  - `scan_idx` (3 bits) increments when `tick` wraps, going 0→1→…→7→0.
- **Frame latch**
  - The shadow registers are `shadow_data` and `shadow_mask`.
  - They capture the inputs on the first cycle after reset deassertion.
  - They also capture the inputs on each cycle where `tick` = `DIGIT_TICKS`-1 and `scan_idx` = 7.
  - `frame_start` pulses on exactly those cycles.
  - Input changes at any other time have no visible effect until the next latch.
- **Blink**
  - `frame_cnt` counts latch events 0..`BLINK_FRAMES`-1.
  - On wrap, `blink_phase` toggles.
  - `blink_phase` = 1 means masked digits are dark.
- **Decode**
  - Codes from `project_pkg` `code_t` map as follows:
  - 0=3F, 1=06, 2=5B, 3=4F, 4=66, 5=6D, 6=7D, 7=07, 8=7F, 9=6F.
  - A=77, B=7C, C=39, D=5E, E=79, H=76, J=1E, P=73, R=50, T=78, BLK=00.
  - Any other code decodes to 00.
  - dp is always 0.
- **Output selection** (per cycle, for the digit at `scan_idx`)
  - Visible digit: `seg_an` = 1<<`scan_idx`, `seg_seg` = decode(`shadow_data`[`scan_idx`]).
  - The digit is dark instead when any of these hold:
    - `tick` < `GUARD_TICKS`;
    - `en` = 0;
    - `shadow_mask`[`scan_idx`] = 0 and `blink_phase` = 1.
  - Dark digit: `seg_an` = 0 and `seg_seg` = 00.
- **Reset**
  - `tick`, `scan_idx`, `frame_cnt` and `blink_phase` = 0.
  - `shadow_data` = all BLK; `shadow_mask` = FF.
  - `seg_an` = 00, `seg_seg` = 00, `frame_start` = 0.
- **Reset mid-frame:** everything returns to reset values on the next edge. The frame is re-latched on the first cycle after release.
- **Simultaneous events:** a latch cycle that is also a `frame_cnt` wrap latches the frame and toggles `blink_phase` on the same edge. The new mask and the new phase both apply from the next slot.

## Timing
- `seg_an` and `seg_seg` are registered, with one cycle of latency from the `tick`/`scan_idx` state they reflect.
  - They change together; a one-cycle mismatch between them is not allowed.
- Slot 0 of a new frame uses the shadow latched on the preceding edge.
- Timing periods:
  - Full frame: 8×`DIGIT_TICKS` cycles.
  - Blink half-period: `BLINK_FRAMES` frames.
- `en` takes effect with one cycle of latency and is not gated by the frame latch.
- There is no handshake: inputs are sampled level-wise and only at latch cycles.

## Test plan
- **Reset and first latch.** Use `DIGIT_TICKS`=4, `GUARD_TICKS`=1, `BLINK_FRAMES`=2. Hold `rst` for 3 cycles, then release with `seg_display_data`={H,E,1,1,0,BLK,BLK,BLK} and `blink_mask`=FF.
  - Outputs are 00 during reset.
  - `frame_start` pulses on the first cycle after release.
  - Slot 0 shows `seg_an`=00 for 1 cycle, then 01 with `seg_seg`=00.
  - Slot 3 shows `seg_an`=08 with `seg_seg`=3F.
  - Slot 7 shows `seg_an`=80 with `seg_seg`=76.
- **Tear-free update.** Change digit 7 from H to E mid-frame (during slot 3).
  - Slot 7 of that frame still shows 76.
  - Slot 7 of the next frame shows 79.
- **Blink.** Set `blink_mask`=7F.
  - Digit 7 is lit for 2 frames, dark (`seg_an`=00) for 2 frames, and the pattern repeats.
  - The other digits stay lit throughout.
- **Enable.** Drop `en` for 5 cycles.
  - `seg_an`=00 one cycle after `en` falls.
  - `scan_idx` and `tick` continue unchanged.
  - The display resumes in the correct slot.
- **Undefined code and reset mid-frame.**
  - A digit with an out-of-enum code gives `seg_seg`=00.
  - Asserting `rst` during slot 5 clears the outputs on the next edge, and scanning restarts at slot 0.
